// File: rtl/multiword_adder_pkg.sv
// Shared types and sizing helpers for the chunk-serial wide adder.
// Optional feature macro: MULTIWORD_ADDER_OVF_EN (signed overflow output).
package multiword_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Keep the counter at least one bit wide even for a single-chunk build.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multiword_adder_seq_if.sv
// Handshake/data bundle for multiword_adder_seq.
// Optional feature macro: MULTIWORD_ADDER_OVF_EN adds the ovf signal.
interface multiword_adder_seq_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef MULTIWORD_ADDER_OVF_EN
  logic             ovf;
`endif

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef MULTIWORD_ADDER_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout, busy
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef MULTIWORD_ADDER_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/multiword_adder_seq_rca_chunk.sv
// CHUNK-bit combinational ripple-carry adder built from 1-bit full adders.
// Optional feature macro: MULTIWORD_ADDER_OVF_EN exposes the carry into the MSB.
module rca_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
`ifdef MULTIWORD_ADDER_OVF_EN
  output logic             c_msb,
`endif
  output logic             co
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[CHUNK];
`ifdef MULTIWORD_ADDER_OVF_EN
  assign c_msb = c[CHUNK-1];
`endif

endmodule

// File: rtl/multiword_adder_seq.sv
// Wide adder that processes one CHUNK-bit slice per cycle, LSB first, carry registered between slices.
// Optional feature macro: MULTIWORD_ADDER_OVF_EN adds a registered signed-overflow flag.
module multiword_adder_seq
  import multiword_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multiword_adder_seq_if.slave bus
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = cnt_width(NCHUNK);

  if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("multiword_adder_seq: WIDTH must be a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_co;
`ifdef MULTIWORD_ADDER_OVF_EN
  logic             chunk_cmsb;
  logic             ovf_q, ovf_d;
`endif

  rca_chunk #(.CHUNK(CHUNK)) u_rca (
    .a     (a_q[CHUNK-1:0]),
    .b     (b_q[CHUNK-1:0]),
    .ci    (carry_q),
    .s     (chunk_sum),
`ifdef MULTIWORD_ADDER_OVF_EN
    .c_msb (chunk_cmsb),
`endif
    .co    (chunk_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef MULTIWORD_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef MULTIWORD_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef MULTIWORD_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Slice sums enter at the top so the LSB slice ends up at bit 0 after NCHUNK shifts.
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        sum_d   = (sum_q >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));
        carry_d = chunk_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NCHUNK - 1)) begin
          state_d = DONE;
`ifdef MULTIWORD_ADDER_OVF_EN
          ovf_d   = chunk_cmsb ^ chunk_co;
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = carry_q;
`ifdef MULTIWORD_ADDER_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule
